// File: rtl/hbm_wr_burst_master_pkg.sv
// Shared types, AXI encodings and helpers for the HBM pseudo-channel write master.
package hbm_wr_burst_master_pkg;

  localparam int ADDR_W           = 33;
  localparam int DATA_W           = 256;
  localparam int STRB_W           = 32;
  localparam int ID_W             = 6;
  localparam int OUT_W            = 5;
  localparam int MAX_BURST_BEATS  = 16;
  localparam int BURST_BYTES      = 512;
  localparam int BURST_ALIGN_BITS = 9;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_32B   = 3'b101;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [STRB_W-1:0] strb_t;
  typedef logic [ID_W-1:0]   id_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // One even-parity bit per data byte.
  function automatic strb_t parity(input data_t d);
    strb_t p;
    for (int i = 0; i < STRB_W; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/hbm_wr_burst_master_if.sv
// AXI3 write channels (AW/W/B) between the burst master and one HBM pseudo-channel.
interface hbm_wr_burst_master_if;
  import hbm_wr_burst_master_pkg::*;

  logic       awvalid;
  logic       awready;
  addr_t      awaddr;
  id_t        awid;
  logic [3:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic       wvalid;
  logic       wready;
  data_t      wdata;
  strb_t      wstrb;
  strb_t      wdata_parity;
  logic       wlast;
  logic       bvalid;
  logic       bready;
  id_t        bid;
  logic [1:0] bresp;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wdata_parity, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wdata_parity, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready
  );

endinterface

// File: rtl/hbm_wr_burst_master_splitter.sv
// Cuts a command into 512 B-aligned INCR bursts of up to 16 beats and issues them on AW,
// one at a time, while the outstanding-burst credit allows it.
module hbm_wr_burst_splitter
  import hbm_wr_burst_master_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int BEATS_W         = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               srst,
  input  logic               start,
  input  logic               enable,
  input  addr_t              base_addr,
  input  logic [BEATS_W-1:0] beats,
  input  logic [OUT_W-1:0]   outstanding,
  input  logic               awready,
  output logic               awvalid,
  output addr_t              awaddr,
  output logic [3:0]         awlen,
  output logic               all_issued
);

  addr_t              next_addr_r;
  logic [BEATS_W-1:0] remaining_r;
  logic [BEATS_W-1:0] burst_beats_s;
  logic               awvalid_r;
  addr_t              awaddr_r;
  logic [3:0]         awlen_r;
  logic               credit_ok_s;
  logic               issue_s;

  // Size of the next burst: a full 16 beats or the tail of the command.
  always_comb begin
    if (remaining_r >= BEATS_W'(MAX_BURST_BEATS)) begin
      burst_beats_s = BEATS_W'(MAX_BURST_BEATS);
    end else begin
      burst_beats_s = remaining_r;
    end
  end

  // Only one AW is pending at a time, so the registered count is never stale at issue.
  assign credit_ok_s = (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign issue_s     = enable & ~awvalid_r & (remaining_r != {BEATS_W{1'b0}}) & credit_ok_s;

  // AW register stage: fields are frozen from issue until awready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr_r <= {ADDR_W{1'b0}};
      remaining_r <= {BEATS_W{1'b0}};
      awvalid_r   <= 1'b0;
      awaddr_r    <= {ADDR_W{1'b0}};
      awlen_r     <= 4'd0;
    end else if (srst) begin
      next_addr_r <= {ADDR_W{1'b0}};
      remaining_r <= {BEATS_W{1'b0}};
      awvalid_r   <= 1'b0;
      awaddr_r    <= {ADDR_W{1'b0}};
      awlen_r     <= 4'd0;
    end else if (start) begin
      next_addr_r <= base_addr;
      remaining_r <= beats;
      awvalid_r   <= 1'b0;
    end else if (awvalid_r) begin
      if (awready) begin
        awvalid_r <= 1'b0;
      end
    end else if (issue_s) begin
      awvalid_r   <= 1'b1;
      awaddr_r    <= next_addr_r;
      awlen_r     <= 4'(burst_beats_s - BEATS_W'(1));
      next_addr_r <= next_addr_r + ADDR_W'(BURST_BYTES);
      remaining_r <= remaining_r - burst_beats_s;
    end
  end

  assign awvalid    = awvalid_r;
  assign awaddr     = awaddr_r;
  assign awlen      = awlen_r;
  assign all_issued = (remaining_r == {BEATS_W{1'b0}}) & ~awvalid_r;

endmodule

// File: rtl/hbm_wr_burst_master.sv
// AXI3 write master for one HBM pseudo-channel: command FSM, W gating behind accepted AW,
// B accounting with done/err reporting.
module hbm_wr_burst_master
  import hbm_wr_burst_master_pkg::*;
#(
  parameter int  MAX_OUTSTANDING = 8,
  parameter id_t AXI_ID          = 6'd0,
  parameter int  BEATS_W         = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               srst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  addr_t              cmd_addr,
  input  logic [BEATS_W-1:0] cmd_beats,
  input  logic               s_valid,
  output logic               s_ready,
  input  data_t              s_data,
  output logic               done,
  output logic               err,
  hbm_wr_burst_master_if.master axi
);

  state_t             state_r;
  state_t             state_s;
  logic               cmd_ready_s;
  logic               run_s;
  logic               drain_s;
  logic [OUT_W-1:0]   outstanding_r;
  logic [BEATS_W-1:0] w_remaining_r;
  logic [3:0]         beat_idx_r;
  logic [BEATS_W-1:0] w_bursts_r;
  logic [BEATS_W-1:0] aw_bursts_r;
  logic               done_r;
  logic               err_r;
  logic               bready_r;
  logic               aw_valid_s;
  addr_t              aw_addr_s;
  logic [3:0]         aw_len_s;
  logic               aw_all_issued_s;
  addr_t              base_addr_s;
  logic               cmd_hs_s;
  logic               aw_hs_s;
  logic               w_hs_s;
  logic               b_hs_s;
  logic               w_allowed_s;
  logic               wlast_s;
  logic               unused_s;

  assign base_addr_s = {cmd_addr[ADDR_W-1:BURST_ALIGN_BITS], {BURST_ALIGN_BITS{1'b0}}};
  assign unused_s    = ^{axi.bid, cmd_addr[BURST_ALIGN_BITS-1:0]};

  assign cmd_hs_s = cmd_valid & cmd_ready_s;
  assign aw_hs_s  = aw_valid_s & axi.awready;
  assign b_hs_s   = axi.bvalid & bready_r;

  // A beat may only belong to a burst whose AW has already been accepted.
  assign w_allowed_s = run_s & (w_remaining_r != {BEATS_W{1'b0}}) & (w_bursts_r < aw_bursts_r);
  assign wlast_s     = (beat_idx_r == 4'd15) | (w_remaining_r == BEATS_W'(1));
  assign w_hs_s      = s_valid & axi.wready & w_allowed_s;

  hbm_wr_burst_splitter #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .BEATS_W         (BEATS_W)
  ) u_splitter (
    .clk         (clk),
    .rst_n       (rst_n),
    .srst        (srst),
    .start       (cmd_hs_s),
    .enable      (run_s),
    .base_addr   (base_addr_s),
    .beats       (cmd_beats),
    .outstanding (outstanding_r),
    .awready     (axi.awready),
    .awvalid     (aw_valid_s),
    .awaddr      (aw_addr_s),
    .awlen       (aw_len_s),
    .all_issued  (aw_all_issued_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else if (srst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; an empty command skips straight to the drain/done step.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_hs_s) begin
          state_s = (cmd_beats == {BEATS_W{1'b0}}) ? ST_DRAIN : ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (aw_all_issued_s && (w_remaining_r == {BEATS_W{1'b0}})) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (outstanding_r == {OUT_W{1'b0}}) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state decode.
  always_comb begin
    cmd_ready_s = 1'b0;
    run_s       = 1'b0;
    drain_s     = 1'b0;
    case (state_r)
      ST_IDLE:  cmd_ready_s = 1'b1;
      ST_RUN:   run_s       = 1'b1;
      ST_DRAIN: drain_s     = 1'b1;
      default:  cmd_ready_s = 1'b0;
    endcase
  end

  // Bursts in flight: AW accepted but B not yet returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_r <= {OUT_W{1'b0}};
    end else if (srst) begin
      outstanding_r <= {OUT_W{1'b0}};
    end else begin
      case ({aw_hs_s, b_hs_s})
        2'b10:   outstanding_r <= outstanding_r + OUT_W'(1);
        2'b01:   outstanding_r <= (outstanding_r != {OUT_W{1'b0}}) ? outstanding_r - OUT_W'(1)
                                                                   : outstanding_r;
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // W beat/burst bookkeeping for wlast and the W-behind-AW rule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_remaining_r <= {BEATS_W{1'b0}};
      beat_idx_r    <= 4'd0;
      w_bursts_r    <= {BEATS_W{1'b0}};
      aw_bursts_r   <= {BEATS_W{1'b0}};
    end else if (srst) begin
      w_remaining_r <= {BEATS_W{1'b0}};
      beat_idx_r    <= 4'd0;
      w_bursts_r    <= {BEATS_W{1'b0}};
      aw_bursts_r   <= {BEATS_W{1'b0}};
    end else if (cmd_hs_s) begin
      w_remaining_r <= cmd_beats;
      beat_idx_r    <= 4'd0;
      w_bursts_r    <= {BEATS_W{1'b0}};
      aw_bursts_r   <= {BEATS_W{1'b0}};
    end else begin
      if (aw_hs_s) begin
        aw_bursts_r <= aw_bursts_r + BEATS_W'(1);
      end
      if (w_hs_s) begin
        w_remaining_r <= w_remaining_r - BEATS_W'(1);
        if (wlast_s) begin
          beat_idx_r <= 4'd0;
          w_bursts_r <= w_bursts_r + BEATS_W'(1);
        end else begin
          beat_idx_r <= beat_idx_r + 4'd1;
        end
      end
    end
  end

  // Status: done pulses on leaving DRAIN; err is sticky for one command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      bready_r <= 1'b0;
    end else if (srst) begin
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      bready_r <= 1'b0;
    end else begin
      done_r   <= drain_s & (outstanding_r == {OUT_W{1'b0}});
      bready_r <= 1'b1;
      if (cmd_hs_s) begin
        err_r <= 1'b0;
      end else if (b_hs_s && (axi.bresp != AXI_RESP_OKAY)) begin
        err_r <= 1'b1;
      end
    end
  end

  assign cmd_ready = cmd_ready_s;
  assign s_ready   = axi.wready & w_allowed_s;
  assign done      = done_r;
  assign err       = err_r;

  assign axi.awvalid      = aw_valid_s;
  assign axi.awaddr       = aw_addr_s;
  assign axi.awid         = AXI_ID;
  assign axi.awlen        = aw_len_s;
  assign axi.awsize       = AXI_SIZE_32B;
  assign axi.awburst      = AXI_BURST_INCR;
  assign axi.wvalid       = s_valid & w_allowed_s;
  assign axi.wdata        = s_data;
  assign axi.wstrb        = {STRB_W{1'b1}};
  assign axi.wdata_parity = parity(s_data);
  assign axi.wlast        = wlast_s;
  assign axi.bready       = bready_r;

endmodule

// File: tb/tb_hbm_wr_burst_master.sv
// Self-checking bench: command vector table plus hand-written credit, parity and reset sequences.
module tb_hbm_wr_burst_master;

  localparam int        MAXO  = 2;
  localparam logic [5:0] TB_ID = 6'h15;

  logic         clk = 1'b0;
  logic         rst_n, srst;
  logic         cmd_valid, cmd_ready;
  logic [32:0]  cmd_addr;
  logic [23:0]  cmd_beats;
  logic         s_valid, s_ready;
  logic [255:0] s_data;
  logic         done, err;

  hbm_wr_burst_master_if axi_if();

  hbm_wr_burst_master #(.MAX_OUTSTANDING(MAXO), .AXI_ID(TB_ID), .BEATS_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .srst(srst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .done(done), .err(err), .axi(axi_if)
  );

  always #5 clk = ~clk;

  typedef struct { logic [32:0] addr; logic [3:0] len; } aw_exp_t;
  typedef struct { logic [255:0] data; logic last; } w_exp_t;
  typedef struct { logic [32:0] addr; logic [23:0] beats; int bad; bit exp_err; } vec_t;

  aw_exp_t      aw_q[$];
  w_exp_t       w_q[$];
  logic [255:0] src_q[$];
  vec_t         vecs[6];

  int checks = 0, errors = 0, cyc = 0;
  bit awready_en, b_en, want_cmd, any_traffic, err_at_done;
  int b_pending, b_seq, bad_idx;
  int aw_cnt, w_cnt, b_cnt, wburst_cnt, done_cnt;
  int last_b_cyc, done_cyc, first_w_cyc, last_w_cyc, cmd_hs_cyc;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_parity(input logic [255:0] d);
    logic [31:0] p = 32'd0;
    for (int i = 0; i < 256; i++) p[i/8] = p[i/8] ^ d[i];
    return p;
  endfunction

  // One clock: drive at the falling edge, then judge the handshakes the next rising edge takes.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    cmd_valid      = want_cmd;
    axi_if.awready = awready_en;
    axi_if.wready  = 1'b1;
    s_valid        = (src_q.size() > 0);
    if (src_q.size() > 0) s_data = src_q[0];
    axi_if.bvalid  = b_en && (b_pending > 0);
    axi_if.bresp   = (b_seq == bad_idx) ? 2'b10 : 2'b00;
    axi_if.bid     = 6'(cyc);
    #1;
    if (axi_if.awvalid || axi_if.wvalid) any_traffic = 1'b1;
    if (cmd_hs_cyc == cyc - 1) chk("err_clear_on_cmd", err, 1'b0);
    if (cmd_valid && cmd_ready) begin
      want_cmd   = 1'b0;
      cmd_hs_cyc = cyc;
    end
    if (axi_if.wvalid && axi_if.wready) begin
      w_exp_t e;
      chk("w_after_aw", 256'(wburst_cnt < aw_cnt), 256'd1);
      chk("s_ready_with_w", s_ready, 1'b1);
      if (w_q.size() == 0) begin
        chk("w_unexpected", 1'b1, 1'b0);
      end else begin
        e = w_q.pop_front();
        chk("wdata", axi_if.wdata, e.data);
        chk("wlast", axi_if.wlast, e.last);
        chk("wdata_parity", axi_if.wdata_parity, ref_parity(e.data));
        chk("wstrb", axi_if.wstrb, 32'hFFFF_FFFF);
        if (e.last) begin
          wburst_cnt++;
          b_pending++;
        end
      end
      if (src_q.size() > 0) void'(src_q.pop_front());
      if (w_cnt == 0) first_w_cyc = cyc;
      last_w_cyc = cyc;
      w_cnt++;
    end
    if (axi_if.awvalid && axi_if.awready) begin
      aw_exp_t a;
      chk("aw_credit", 256'((aw_cnt - b_cnt) < MAXO), 256'd1);
      if (aw_q.size() == 0) begin
        chk("aw_unexpected", 1'b1, 1'b0);
      end else begin
        a = aw_q.pop_front();
        chk("awaddr", axi_if.awaddr, a.addr);
        chk("awlen", axi_if.awlen, a.len);
        chk("aw_fixed_fields", {axi_if.awid, axi_if.awsize, axi_if.awburst}, {TB_ID, 3'b101, 2'b01});
      end
      aw_cnt++;
    end
    if (axi_if.bvalid && axi_if.bready) begin
      b_pending--;
      b_seq++;
      b_cnt++;
      last_b_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc    = cyc;
      err_at_done = err;
    end
  endtask

  task automatic start_cmd(input logic [32:0] addr, input logic [23:0] beats, input int bad,
                           input bit small_first);
    logic [32:0]  base;
    int           rem, n, k;
    logic [255:0] d;
    aw_q.delete(); w_q.delete(); src_q.delete();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; wburst_cnt = 0; done_cnt = 0; b_seq = 0; b_pending = 0;
    any_traffic = 1'b0; bad_idx = bad; cmd_hs_cyc = -10; last_b_cyc = -1; done_cyc = -1;
    base = {addr[32:9], 9'd0};
    rem = int'(beats);
    k = 0;
    while (rem > 0) begin
      n = (rem > 16) ? 16 : rem;
      aw_q.push_back('{addr: base + 33'(k * 512), len: 4'(n - 1)});
      rem -= n;
      k++;
    end
    for (int i = 0; i < int'(beats); i++) begin
      d = (small_first && i == 0) ? 256'h07
                                  : {$urandom, $urandom, $urandom, $urandom,
                                     $urandom, $urandom, $urandom, $urandom};
      src_q.push_back(d);
      w_q.push_back('{data: d, last: ((i % 16) == 15) || (i == int'(beats) - 1)});
    end
    cmd_addr  = addr;
    cmd_beats = beats;
    want_cmd  = 1'b1;
  endtask

  task automatic wait_done(input bit exp_err, input int beats, input bit tput);
    int n = 0;
    while (done_cnt == 0 && n < 600) begin
      cycle();
      n++;
    end
    chk("done_timeout", 256'(done_cnt > 0), 256'd1);
    repeat (3) cycle();
    chk("done_single_pulse", done_cnt, 1);
    chk("err_with_done", err_at_done, exp_err);
    chk("err_held", err, exp_err);
    chk("aw_all_seen", aw_q.size(), 0);
    chk("w_all_seen", w_q.size(), 0);
    chk("b_all_returned", b_pending, 0);
    if (beats == 0) begin
      chk("empty_done_timing", done_cyc - cmd_hs_cyc, 2);
      chk("empty_no_traffic", any_traffic, 1'b0);
    end else begin
      chk("done_after_last_b", done_cyc - last_b_cyc, 2);
      if (tput) chk("w_throughput", last_w_cyc - first_w_cyc, beats - 1);
    end
  endtask

  initial begin
    vecs[0] = '{addr: 33'h0_0000_0000, beats: 24'd40, bad: -1, exp_err: 1'b0};
    vecs[1] = '{addr: 33'h0_0000_0000, beats: 24'd0,  bad: -1, exp_err: 1'b0};
    vecs[2] = '{addr: 33'h0_0000_1234, beats: 24'd33, bad:  1, exp_err: 1'b1};
    vecs[3] = '{addr: 33'h1_FFFF_FC00, beats: 24'd16, bad: -1, exp_err: 1'b0};
    vecs[4] = '{addr: 33'h0_0040_01FF, beats: 24'd17, bad:  0, exp_err: 1'b1};
    vecs[5] = '{addr: 33'h0_0000_0400, beats: 24'd1,  bad: -1, exp_err: 1'b0};

    rst_n = 1'b0; srst = 1'b0; cmd_valid = 1'b0; cmd_addr = 33'd0; cmd_beats = 24'd0;
    s_valid = 1'b0; s_data = 256'd0; want_cmd = 1'b0; awready_en = 1'b1; b_en = 1'b1;
    axi_if.awready = 1'b0; axi_if.wready = 1'b0; axi_if.bvalid = 1'b0;
    axi_if.bresp = 2'b00; axi_if.bid = 6'd0;
    b_pending = 0; bad_idx = -1; cmd_hs_cyc = -10;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    chk("reset_outputs", {axi_if.awvalid, axi_if.wvalid, done, err}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("bready_after_reset", axi_if.bready, 1'b1);

    for (int v = 0; v < 6; v++) begin
      start_cmd(vecs[v].addr, vecs[v].beats, vecs[v].bad, 1'b0);
      wait_done(vecs[v].exp_err, int'(vecs[v].beats), 1'b1);
    end

    // Two credits, no B returned: only two bursts may go out.
    b_en = 1'b0;
    start_cmd(33'h0_0000_2000, 24'd64, -1, 1'b0);
    repeat (60) cycle();
    chk("credit_aw_count", aw_cnt, 2);
    chk("credit_awvalid_low", axi_if.awvalid, 1'b0);
    chk("credit_w_count", w_cnt, 32);
    chk("credit_s_ready_low", s_ready, 1'b0);
    b_en = 1'b1;
    wait_done(1'b0, 64, 1'b0);

    // No AW accepted: W must stay blocked; parity of a single 0x07 byte.
    awready_en = 1'b0;
    start_cmd(33'h0_0000_0800, 24'd16, -1, 1'b1);
    repeat (8) cycle();
    chk("blocked_s_ready", s_ready, 1'b0);
    chk("blocked_wvalid", axi_if.wvalid, 1'b0);
    chk("parity_byte0", axi_if.wdata_parity, 32'h0000_0001);
    chk("blocked_aw_held", {axi_if.awvalid, axi_if.awaddr, axi_if.awlen}, {1'b1, 33'h0_0000_0800, 4'd15});
    awready_en = 1'b1;
    wait_done(1'b0, 16, 1'b0);

    // Asynchronous reset in the middle of a burst.
    start_cmd(33'h0_0000_4000, 24'd16, -1, 1'b0);
    for (int n = 0; n < 200 && w_cnt < 5; n++) cycle();
    chk("reset_mid_w_count", w_cnt, 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {axi_if.awvalid, axi_if.wvalid, done}, 3'b000);
    aw_q.delete(); w_q.delete(); src_q.delete();
    b_pending = 0; want_cmd = 1'b0; s_valid = 1'b0; axi_if.bvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("post_reset_cmd_ready", cmd_ready, 1'b1);
    chk("post_reset_quiet", {axi_if.awvalid, axi_if.wvalid, done, err}, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hbm_wr_burst_master.md
Name: hbm_wr_burst_master

Overview:
- Write-side AXI3 master for one HBM pseudo-channel (PC).
- Accepts a command (base address, beat count) and a 256-bit data stream.
- Splits the transfer into INCR bursts of up to 16 beats and issues AW/W with per-byte parity.
- Counts B responses and reports done/err; sits between the NTT data movers and the HBM PC port.

Parameters:
- MAX_OUTSTANDING, 8: maximum AW bursts issued whose B has not yet returned (1..16).
- AXI_ID, 0: constant value driven on awid (rid_t/wid_t width, 6 bits).
- BEATS_W, 24: width of cmd_beats.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- cmd_addr  in  33  byte address (addr_t); bits [8:0] ignored, treated as 0
- cmd_beats  in  BEATS_W  number of 32-byte beats
- s_valid  in  1  input data valid
- s_ready  out  1  input data ready
- s_data  in  256  input data (data_t)
- done  out  1  one-cycle pulse when the command completes
- err  out  1  any non-OKAY bresp seen in the last command; valid with done, held until the next command is accepted
- awvalid  out  1  AW valid
- awready  in  1  AW ready
- awaddr  out  33  burst address
- awid  out  6  driven with AXI_ID
- awlen  out  4  burst length minus 1
- awsize  out  3  constant 3'b101 (32 B)
- awburst  out  2  constant 2'b01 (INCR)
- wvalid  out  1  W valid
- wready  in  1  W ready
- wdata  out  256  write data
- wstrb  out  32  all ones
- wdata_parity  out  32  per-byte XOR parity of wdata
- wlast  out  1  last beat of a burst
- bvalid  in  1  B valid
- bready  out  1  B ready
- bid  in  6  B id (ignored)
- bresp  in  2  B response

Behaviour:
- Reset: async on rst_n low. State IDLE; all counters 0; awvalid, wvalid, done, err = 0; cmd_ready = 1 (IDLE). bready = 1 at all times after reset. Reset mid-transfer abandons in-flight bursts; the HBM side must be reset together.
- FSM IDLE -> RUN -> DRAIN -> IDLE.
  - IDLE: cmd handshake latches addr[32:9]<<9 and beats, clears err.
  - cmd_beats == 0: go directly to DRAIN, which pulses done the next cycle with no AXI traffic.
  - RUN: lasts until all AW and W beats have handshaked, then DRAIN.
  - DRAIN: waits until the outstanding count reaches 0, pulses done for 1 cycle, returns to IDLE.
- AW generation:
  - Burst k: awaddr = base + k*512; awlen = 15, except the final burst where awlen = (remaining beats - 1).
  - 512 B alignment guarantees no 4 KB crossing.
  - awvalid is registered; once asserted, awvalid and all AW fields stay stable until awready.
  - No new AW while outstanding == MAX_OUTSTANDING.
- Outstanding counter: +1 on AW handshake, -1 on B handshake; both in the same cycle leaves it unchanged.
- W path:
  - A beat is allowed only while the number of W bursts started is less than the number of AW bursts accepted (W never leads AW).
  - wvalid = s_valid & allowed; s_ready = wready & allowed & RUN. Combinational passthrough, 0 latency.
  - wdata = s_data; wdata_parity = parity(wdata).
  - wlast is asserted on beat 16 of each full burst and on the final beat of the command.
- err sets on any B handshake with bresp != 2'b00.
- Throughput: with awready, wready and s_valid all held high, 1 W beat per cycle.

Decomposition:
- axi_hbm_pkg additions:
  - AXI_BURST_INCR = 2'b01
  - AXI_SIZE_32B = 3'b101
  - AXI_RESP_OKAY = 2'b00
  - MAX_BURST_BEATS = 16
  - BURST_BYTES = 512
  - parity() for wdata_parity
- Sub-module hbm_wr_burst_splitter: generates AW address/length from base and beats, with an outstanding-credit input.
- Top level holds the FSM, the W gating and the B accounting.

Test Plan:
1. cmd_addr 0x0, cmd_beats 40, all ready → AW 0x000/len15, 0x200/len15, 0x400/len7; 40 W beats with wlast on beats 16, 32, 40; done one cycle after the third B.
2. cmd_beats 0 → done pulses the cycle after DRAIN entry; no awvalid or wvalid ever asserted.
3. MAX_OUTSTANDING=2, bvalid held 0, cmd_beats 64 → exactly 2 AW handshakes; awvalid stays 0 until the first B, then the third AW issues.
4. bresp 2'b10 on the second of 3 B → err=1 together with done; err clears on the next cmd handshake.
5. s_data byte0=0x07, all other bytes 0 → wdata_parity=32'h0000_0001; awready held 0 → no W beat is accepted (s_ready=0).
6. rst_n low after 5 W beats of a 16-beat burst → awvalid/wvalid/done 0 immediately; cmd_ready=1 on the first cycle after release.
